// File: rtl/pwm_fade_bank_if.sv
// rtl/pwm_fade_bank_if.sv - per-channel trigger/mode inputs and drive/busy outputs of the fade bank
interface pwm_fade_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] trigger;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] drive;
    logic [CHANNELS-1:0] busy;

    modport master (output trigger, output mode, input drive, input busy);
    modport slave  (input trigger, input mode, output drive, output busy);
endinterface

// File: rtl/pwm_fade_bank.sv
// rtl/pwm_fade_bank.sv - multi-channel LED fader: hold at full, linear fade, optional breathing
module pwm_fade_bank #(
    parameter int CHANNELS    = 4,
    parameter int LEVEL_BITS  = 8,
    parameter int FADE_BITS   = 26,
    parameter int HOLD_CYCLES = 1 << 24
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_fade_bank_if.slave  bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [FADE_BITS-1:0] FADE_MAX  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FADE, ST_RISE} state_e;

    state_e                state_q [CHANNELS];
    state_e                state_d [CHANNELS];
    logic [HOLD_W-1:0]     hold_q  [CHANNELS];
    logic [HOLD_W-1:0]     hold_d  [CHANNELS];
    logic [FADE_BITS-1:0]  fade_q  [CHANNELS];
    logic [FADE_BITS-1:0]  fade_d  [CHANNELS];
    logic [LEVEL_BITS-1:0] pwm_q;
    logic [LEVEL_BITS-1:0] pwm_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= ST_IDLE;
                hold_q[c]  <= '0;
                fade_q[c]  <= '0;
            end
        end else begin
            pwm_q <= pwm_d;
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                hold_q[c]  <= hold_d[c];
                fade_q[c]  <= fade_d[c];
            end
        end
    end

    // Trigger overrides everything; otherwise each state advances its own counter.
    always_comb begin
        pwm_d = pwm_q + LEVEL_BITS'(1);
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            hold_d[c]  = hold_q[c];
            fade_d[c]  = fade_q[c];
            if (bus.trigger[c]) begin
                fade_d[c] = FADE_MAX;
                if (HOLD_CYCLES > 0) begin
                    state_d[c] = ST_HOLD;
                    hold_d[c]  = HOLD_LOAD;
                end else begin
                    state_d[c] = ST_FADE;
                end
            end else begin
                case (state_q[c])
                    ST_IDLE: begin
                        if (bus.mode[c]) begin
                            state_d[c] = ST_RISE;
                            fade_d[c]  = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_q[c] == '0) state_d[c] = ST_FADE;
                        else                 hold_d[c]  = hold_q[c] - HOLD_W'(1);
                    end
                    ST_FADE: begin
                        if (fade_q[c] == '0) state_d[c] = bus.mode[c] ? ST_RISE : ST_IDLE;
                        else                 fade_d[c]  = fade_q[c] - FADE_BITS'(1);
                    end
                    ST_RISE: begin
                        // Dropping mode mid-rise decays from the current level, so no visible jump.
                        if (!bus.mode[c] || fade_q[c] == FADE_MAX) state_d[c] = ST_FADE;
                        else                                        fade_d[c]  = fade_q[c] + FADE_BITS'(1);
                    end
                    default: state_d[c] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.drive = '0;
        bus.busy  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.busy[c] = (state_q[c] != ST_IDLE);
            case (state_q[c])
                ST_HOLD: bus.drive[c] = 1'b1;
                ST_FADE,
                ST_RISE: bus.drive[c] = (pwm_q < fade_q[c][FADE_BITS-1 -: LEVEL_BITS]);
                default: bus.drive[c] = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_fade_bank.sv
// tb/tb_pwm_fade_bank.sv - randomized and directed bench against a brightness/direction model
module tb_pwm_fade_bank;
    localparam int CH     = 2;
    localparam int LB     = 2;
    localparam int FB     = 4;
    localparam int HOLD   = 3;
    localparam int BMAX   = (1 << FB) - 1;
    localparam int PERIOD = 1 << LB;
    localparam int SHIFT  = FB - LB;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    pwm_fade_bank_if #(.CHANNELS(CH)) bus ();

    pwm_fade_bank #(
        .CHANNELS(CH), .LEVEL_BITS(LB), .FADE_BITS(FB), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a lit channel is either holding (hold_left > 0) or moving its brightness by dir.
    int m_bright [CH];
    int m_dir    [CH];
    int m_hold   [CH];
    bit m_lit    [CH];
    int m_pwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pwm = 0;
        for (int c = 0; c < CH; c++) begin
            m_bright[c] = 0; m_dir[c] = 0; m_hold[c] = 0; m_lit[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] trg, md;
        trg = bus.trigger;
        md  = bus.mode;
        m_pwm = (m_pwm + 1) % PERIOD;
        for (int c = 0; c < CH; c++) begin
            if (trg[c]) begin
                m_lit[c] = 1; m_bright[c] = BMAX; m_dir[c] = -1; m_hold[c] = HOLD;
            end else if (!m_lit[c]) begin
                if (md[c]) begin m_lit[c] = 1; m_bright[c] = 0; m_dir[c] = 1; end
            end else if (m_hold[c] > 0) begin
                m_hold[c]--;
            end else if (m_dir[c] < 0) begin
                if (m_bright[c] > 0) m_bright[c]--;
                else if (md[c])      m_dir[c] = 1;
                else                 m_lit[c] = 0;
            end else begin
                if (!md[c] || m_bright[c] == BMAX) m_dir[c] = -1;
                else                               m_bright[c]++;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [CH-1:0] exp_drive, exp_busy;
        for (int c = 0; c < CH; c++) begin
            exp_busy[c]  = m_lit[c];
            exp_drive[c] = m_lit[c] && (m_hold[c] > 0 || m_pwm < (m_bright[c] >> SHIFT));
        end
        check("drive", 32'(bus.drive), 32'(exp_drive));
        check("busy",  32'(bus.busy),  32'(exp_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        int n;
        int busy_cycles;
        rst_n = 1'b0;
        bus.trigger = '0;
        bus.mode    = '0;
        model_reset();
        #1;
        check("reset_drive", 32'(bus.drive), 0);
        check("reset_busy",  32'(bus.busy),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();

        // One-shot on channel 0
        bus.trigger = 2'b01;
        busy_cycles = 0;
        tick();
        bus.trigger = 2'b00;
        if (bus.busy[0]) busy_cycles++;
        check("oneshot_drive_n", 32'(bus.drive[0]), 1);
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.busy[0]) busy_cycles++;
            check("oneshot_ch1_quiet", 32'({bus.drive[1], bus.busy[1]}), 0);
        end
        check("oneshot_busy_len", busy_cycles, HOLD + (1 << FB));

        // Retrigger mid-fade at brightness 6
        bus.trigger = 2'b01;
        tick();
        bus.trigger = 2'b00;
        n = 0;
        while (!(m_hold[0] == 0 && m_dir[0] < 0 && m_bright[0] == 6) && n < 40) begin
            tick(); n++;
        end
        check("retrig_reach", 32'(n < 40), 1);
        bus.trigger = 2'b01;
        tick();
        bus.trigger = 2'b00;
        check("retrig_drive", 32'(bus.drive[0]), 1);
        repeat (25) tick();

        // Breathe on channel 1 for three periods
        bus.mode = 2'b10;
        for (int i = 0; i < 3 * 2 * (1 << FB); i++) begin
            tick();
            check("breathe_busy", 32'(bus.busy[1]), 1);
        end
        n = 0;
        while (!(m_dir[1] > 0 && m_bright[1] == 9) && n < 40) begin
            tick(); n++;
        end
        check("drop_reach", 32'(n < 40), 1);
        bus.mode = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        check("drop_busy_last", 32'(bus.busy[1]), 1);
        tick();
        check("drop_idle", 32'(bus.busy[1]), 0);

        // Simultaneous triggers give identical waveforms
        bus.trigger = 2'b11;
        tick();
        bus.trigger = 2'b00;
        for (int i = 0; i < 24; i++) begin
            tick();
            check("sim_match", 32'(bus.drive[0]), 32'(bus.drive[1]));
        end

        // Trigger together with mode rise wins and holds
        bus.trigger = 2'b01;
        bus.mode    = 2'b01;
        tick();
        bus.trigger = 2'b00;
        for (int i = 0; i < HOLD; i++) begin
            check("trig_mode_hold", 32'(bus.drive[0]), 1);
            if (i < HOLD - 1) tick();
        end
        repeat (40) tick();
        bus.mode = 2'b00;

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < CH; c++) begin
                bus.trigger[c] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 59) == 0) bus.mode[c] = ~bus.mode[c];
            end
            tick();
        end
        bus.trigger = 2'b00;
        bus.mode    = 2'b00;

        // Asynchronous reset pulse with no clock edge while low
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_drive", 32'(bus.drive), 0);
        check("async_rst_busy",  32'(bus.busy),  0);
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("post_rst_quiet", 32'({bus.drive, bus.busy}), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_fade_bank.md
# pwm_fade_bank

Multi-channel LED fader for miner status indicators, such as share found, nonce wrap and link activity. Every channel shares one free-running PWM counter. On a trigger, a channel shows true full brightness for a programmable hold time, then fades linearly to true black. Each channel can also "breathe" continuously, rising and falling between black and full brightness, while its mode bit is set. Instantiated once per board top, next to the miner cores; triggers come from core result strobes.

## Interface
- `CHANNELS`, default 4: number of independent fade channels.
- `LEVEL_BITS`, default 8: PWM resolution; the shared counter period is 2^LEVEL_BITS cycles.
- `FADE_BITS`, default 26: width of each channel's fade counter. A full fade or rise takes 2^FADE_BITS−1 cycles. Must be ≥ LEVEL_BITS.
- `HOLD_CYCLES`, default 2^24: number of full-brightness cycles after a trigger. 0 means no hold.
- `clk` — in — 1 — sole clock; all state changes on its rising edge.
- `rst_n` — in — 1 — asynchronous, active-low reset.
- `trigger` — in — CHANNELS — per-channel start/restart pulse, sampled at posedge clk. Level-held is legal.
- `mode` — in — CHANNELS — per channel: 0 = one-shot fade, 1 = breathe.
- `drive` — out — CHANNELS — LED drive, 1 = on.
- `busy` — out — CHANNELS — 1 while the channel is not IDLE.

## Operation
- Shared `pwm_cnt` (LEVEL_BITS) increments every cycle and wraps from all-ones to 0.
- Each channel has:
  - a state register: IDLE, HOLD, FADE or RISE;
  - `hold_cnt`, wide enough for HOLD_CYCLES;
  - `fade_cnt` (FADE_BITS).
- `level` = `fade_cnt[FADE_BITS-1 : FADE_BITS-LEVEL_BITS]`.
- `drive` per state:
  - IDLE: constant 0 (true black).
  - HOLD: constant 1 (true full).
  - FADE or RISE: `pwm_cnt < level`, unsigned compare.
- Transitions are evaluated per channel, highest priority first:
  1. `trigger`=1, any state:
     - if HOLD_CYCLES>0: go to HOLD, `hold_cnt` ← HOLD_CYCLES−1, `fade_cnt` ← all-ones;
     - otherwise: go to FADE, `fade_cnt` ← all-ones.
  2. IDLE with `mode`=1: go to RISE, `fade_cnt` ← 0.
  3. HOLD:
     - if `hold_cnt`==0, go to FADE, with `fade_cnt` left at all-ones;
     - otherwise decrement `hold_cnt`.
  4. FADE:
     - if `fade_cnt`==0, go to RISE when `mode`=1, else to IDLE;
     - otherwise decrement `fade_cnt`.
  5. RISE:
     - if `mode`=0, go to FADE and keep the current `fade_cnt` (smooth decay, no jump);
     - else if `fade_cnt`==all-ones, go to FADE;
     - otherwise increment `fade_cnt`.
- `mode` is ignored in HOLD. After the hold, a breathing channel fades down and then resumes RISE.
- Channels are fully independent. Simultaneous triggers on several channels are all honoured in the same cycle.
- `busy` = (state ≠ IDLE).

## Timing
- Reset (`rst_n`=0, asynchronous): every state ← IDLE; `pwm_cnt`, `hold_cnt` and `fade_cnt` ← 0; `drive`=0 and `busy`=0 immediately, with no clock edge needed.
- Deassertion of `rst_n` is synchronised externally. The first active edge after release behaves as a normal cycle.
- `drive` and `busy` are decoded combinationally from registers only. There is no input-to-output combinational path.
- Trigger latency: the trigger is sampled at edge N; `drive`=1 and `busy`=1 from just after edge N.
- HOLD lasts exactly HOLD_CYCLES cycles, then FADE starts at `fade_cnt` = all-ones.
- One-shot FADE from all-ones to IDLE takes 2^FADE_BITS cycles: 2^FADE_BITS−1 decrements plus 1 exit cycle.
- Breathe period from RISE at 0 back to RISE at 0 is 2·2^FADE_BITS cycles.
- A trigger held high keeps the channel in HOLD with `hold_cnt` reloaded every cycle. The hold ends HOLD_CYCLES cycles after `trigger` falls.
- A `mode` change in FADE takes effect only at `fade_cnt`==0. In RISE it takes effect on the next edge.
- No arithmetic wrap: `fade_cnt` never decrements below 0 or increments past all-ones.

## Test plan
Bench parameters: CHANNELS=2, LEVEL_BITS=2, FADE_BITS=4, HOLD_CYCLES=3.
- **Reset:** pulse `rst_n` low mid-simulation, with no clock edge during the low phase → `drive`=00 and `busy`=00 at once. After release with no triggers, outputs stay 00 for 100 cycles.
- **One-shot:** 1-cycle `trigger[0]` at edge N →
  - `drive[0]`=1 for 3 cycles;
  - FADE from `fade_cnt`=15, `level` going 3,3,3,3,2,…,0;
  - `drive[0]` = (`pwm_cnt` < `level`) every cycle;
  - IDLE and `busy[0]`=0 after 3+16 cycles;
  - `drive[1]` and `busy[1]` stay 0 throughout.
- **Retrigger:** `trigger[0]` at `fade_cnt`=6 during FADE → `drive[0]`=1 on the next cycle, a full 3-cycle HOLD, then FADE from 15.
- **Breathe:** `mode[1]`=1 from IDLE → RISE 0→15, then FADE 15→0, period 32 cycles, repeated 3 times; `busy[1]`=1 throughout.
- **Mode drop:** `mode[1]`→0 while RISE is at `fade_cnt`=9 → FADE from 9, IDLE after 10 further cycles, no `level` jump.
- **Simultaneous events:**
  - triggers on both channels in the same cycle → identical `drive` waveforms;
  - `trigger[0]` asserted together with a `mode` change → trigger wins and the channel goes to HOLD.
